// File: rtl/bm_rdresp_tx.sv
`default_nettype none
// ============================================================================
// Module  : bm_rdresp_tx
// Brief   : Sends each accepted register-read response as one framed 8N1
//           UART packet on tx_o. Define BM_TX_CHECKSUM_EN to append an XOR
//           checksum byte to every frame.
// Rev     : 1.0
// ============================================================================
module bm_rdresp_tx #(
    parameter int BAUD_DIV = 434
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        resp_valid_i,
    output logic        resp_ready_o,
    input  logic [21:0] resp_addr_i,
    input  logic [31:0] resp_data_i,
    input  logic        resp_err_i,
    output logic        tx_o,
    output logic        busy_o
);

    localparam int             BW          = $clog2(BAUD_DIV);
    localparam logic [BW-1:0]  C_BAUD_LAST = BW'(BAUD_DIV - 1);
`ifdef BM_TX_CHECKSUM_EN
    localparam logic [2:0]     C_LAST_BYTE = 3'd7;
`else
    localparam logic [2:0]     C_LAST_BYTE = 3'd6;
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [BW-1:0]   r_baud, w_baud_nxt;
    logic [2:0]      r_bit, w_bit_nxt;
    logic [2:0]      r_byte, w_byte_nxt;
    logic [21:0]     r_addr;
    logic [31:0]     r_data;
    logic            r_err;
    logic            r_tx;
    logic            w_tx_nxt;
    logic            w_baud_done;
    logic            w_accept;
    logic [7:0]      w_cur_byte;

    assign w_baud_done  = (r_baud == '0);
    assign w_accept     = (r_state == S_IDLE) && resp_valid_i;
    assign resp_ready_o = (r_state == S_IDLE);
    assign busy_o       = (r_state != S_IDLE);
    assign tx_o         = r_tx;

`ifdef BM_TX_CHECKSUM_EN
    logic [7:0] w_cksum;
    assign w_cksum = {1'b1, r_err, r_addr[21:16]} ^ r_addr[15:8] ^ r_addr[7:0]
                   ^ r_data[31:24] ^ r_data[23:16] ^ r_data[15:8] ^ r_data[7:0];
`endif

    always_comb begin
        w_cur_byte = 8'hFF;
        case (r_byte)
            3'd0: w_cur_byte = {1'b1, r_err, r_addr[21:16]};
            3'd1: w_cur_byte = r_addr[15:8];
            3'd2: w_cur_byte = r_addr[7:0];
            3'd3: w_cur_byte = r_data[31:24];
            3'd4: w_cur_byte = r_data[23:16];
            3'd5: w_cur_byte = r_data[15:8];
            3'd6: w_cur_byte = r_data[7:0];
`ifdef BM_TX_CHECKSUM_EN
            3'd7: w_cur_byte = w_cksum;
`endif
            default: w_cur_byte = 8'hFF;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_baud_nxt  = r_baud;
        w_bit_nxt   = r_bit;
        w_byte_nxt  = r_byte;
        case (r_state)
            S_IDLE: begin
                if (resp_valid_i) begin
                    w_state_nxt = S_START;
                    w_baud_nxt  = C_BAUD_LAST;
                    w_bit_nxt   = 3'd0;
                    w_byte_nxt  = 3'd0;
                end
            end
            S_START: begin
                if (w_baud_done) begin
                    w_state_nxt = S_DATA;
                    w_baud_nxt  = C_BAUD_LAST;
                    w_bit_nxt   = 3'd0;
                end else begin
                    w_baud_nxt  = r_baud - 1'b1;
                end
            end
            S_DATA: begin
                if (w_baud_done) begin
                    w_baud_nxt = C_BAUD_LAST;
                    if (r_bit == 3'd7) begin
                        w_state_nxt = S_STOP;
                    end else begin
                        w_bit_nxt   = r_bit + 3'd1;
                    end
                end else begin
                    w_baud_nxt = r_baud - 1'b1;
                end
            end
            S_STOP: begin
                if (w_baud_done) begin
                    if (r_byte == C_LAST_BYTE) begin
                        w_state_nxt = S_IDLE;
                        w_baud_nxt  = '0;
                        w_bit_nxt   = 3'd0;
                        w_byte_nxt  = 3'd0;
                    end else begin
                        w_state_nxt = S_START;
                        w_baud_nxt  = C_BAUD_LAST;
                        w_byte_nxt  = r_byte + 3'd1;
                    end
                end else begin
                    w_baud_nxt = r_baud - 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Line level is registered from the next state so tx_o never glitches.
    always_comb begin
        w_tx_nxt = 1'b1;
        case (w_state_nxt)
            S_START: w_tx_nxt = 1'b0;
            S_DATA:  w_tx_nxt = w_cur_byte[w_bit_nxt];
            default: w_tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= S_IDLE;
            r_baud  <= '0;
            r_bit   <= 3'd0;
            r_byte  <= 3'd0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_baud  <= w_baud_nxt;
            r_bit   <= w_bit_nxt;
            r_byte  <= w_byte_nxt;
            r_tx    <= w_tx_nxt;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_addr <= '0;
            r_data <= '0;
            r_err  <= 1'b0;
        end else if (w_accept) begin
            r_addr <= resp_addr_i;
            r_data <= resp_data_i;
            r_err  <= resp_err_i;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bm_rdresp_tx.sv
`default_nettype none
// ============================================================================
// Module  : tb_bm_rdresp_tx
// Brief   : Self-checking bench for bm_rdresp_tx with a frame-level line model.
// Rev     : 1.0
// ============================================================================
module tb_bm_rdresp_tx;

    localparam int BD = 4;
`ifdef BM_TX_CHECKSUM_EN
    localparam int NB       = 8;
    localparam int EXP_RDY  = 320;
`else
    localparam int NB       = 7;
    localparam int EXP_RDY  = 280;
`endif
    localparam int F = NB * 10 * BD;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid = 1'b0;
    logic [21:0] addr = '0;
    logic [31:0] data = '0;
    logic        err = 1'b0;
    logic        ready, tx, busy;

    int n_cmp = 0;
    int n_err = 0;
    bit cmp_en = 1'b0;

    bm_rdresp_tx #(.BAUD_DIV(BD)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .resp_valid_i(valid), .resp_ready_o(ready),
        .resp_addr_i(addr), .resp_data_i(data), .resp_err_i(err),
        .tx_o(tx), .busy_o(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame packed with B0 in the top byte.
    function automatic logic [63:0] build(input logic [21:0] a, input logic [31:0] d, input logic e);
        logic [55:0] b;
        logic [7:0]  x;
        b = {1'b1, e, a, d};
        x = 8'h00;
        for (int j = 0; j < 7; j++) x ^= b[55-8*j -: 8];
        if (NB == 8) return {b, x};
        return {b, 8'h00};
    endfunction

    logic [63:0] m_frame = '0;
    bit          m_active = 1'b0;
    int          m_t = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active <= 1'b0;
            m_t      <= 0;
        end else if (m_active) begin
            if (m_t == F - 1) m_active <= 1'b0;
            m_t <= m_t + 1;
        end else if (valid) begin
            m_active <= 1'b1;
            m_t      <= 0;
            m_frame  <= build(addr, data, err);
        end
    end

    function automatic logic exp_tx();
        int pos, j;
        if (!m_active) return 1'b1;
        j   = m_t / (10 * BD);
        pos = (m_t % (10 * BD)) / BD;
        if (pos == 0) return 1'b0;
        if (pos == 9) return 1'b1;
        return m_frame[63 - 8*j - 7 + (pos - 1)];
    endfunction

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("line_tx", tx, exp_tx());
            chk("line_busy", busy, m_active);
            chk("line_ready", ready, !m_active);
        end
    end

    logic [7:0] rx_b [8];
    logic       rx_start0;
    int         rdy_at;

    // Starts at the first negedge after acceptance and ends at negedge t = F.
    task automatic rx_frame();
        int pos;
        rdy_at = -1;
        for (int t = 0; t <= F; t++) begin
            @(negedge clk);
            if (t == 0) rx_start0 = tx;
            pos = (t % (10 * BD)) / BD;
            if (t < F && pos >= 1 && pos <= 8 && (t % BD) == BD / 2)
                rx_b[t / (10 * BD)][pos - 1] = tx;
            if (ready && rdy_at < 0) rdy_at = t;
        end
    endtask

    task automatic present(input logic [21:0] a, input logic [31:0] d, input logic e);
        int k;
        @(negedge clk);
        addr = a; data = d; err = e; valid = 1'b1;
        k = 0;
        while (m_active && k < 5000) begin
            @(negedge clk);
            k++;
        end
        if (m_active) begin
            chk("accept_timeout", 1, 0);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_frame(input string name, input logic [63:0] exp);
        for (int j = 0; j < NB; j++) chk(name, rx_b[j], exp[63-8*j -: 8]);
        chk({name, "_start"}, rx_start0, 1'b0);
    endtask

    logic [63:0] lit1, lit2;

    initial begin
        lit1 = 64'h83_04_04_00_00_00_02_81;
        lit2 = 64'hFF_FF_FF_DE_AD_BE_EF_DD;

        // Reset
        repeat (3) @(negedge clk);
        chk("rst_tx", tx, 1'b1);
        chk("rst_ready", ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        rst_n = 1'b1;
        cmp_en = 1'b1;
        begin
            int hi;
            hi = 0;
            for (int i = 0; i < 1000; i++) begin
                @(negedge clk);
                if (tx === 1'b1) hi++;
            end
            chk("idle_1000", hi, 1000);
        end

        // Single frame
        present(22'h030404, 32'h00000002, 1'b0);
        valid = 1'b0;
        rx_frame();
        chk_frame("single", lit1);
        chk("single_ready_lat", rdy_at, EXP_RDY);

        // Error flag
        present(22'h3FFFFF, 32'hDEADBEEF, 1'b1);
        valid = 1'b0;
        rx_frame();
        chk_frame("errflag", lit2);
        chk("errflag_ready_lat", rdy_at, EXP_RDY);

        // Back-to-back with inputs changed during frame 1
        present(22'h12A5C3, 32'h0F1E2D3C, 1'b0);
        addr = 22'h2B0071; data = 32'h89ABCDEF; err = 1'b1;
        rx_frame();
        chk_frame("b2b_f1", build(22'h12A5C3, 32'h0F1E2D3C, 1'b0));
        chk("b2b_gap_high", tx, 1'b1);
        @(posedge clk);
        #1;
        valid = 1'b0;
        rx_frame();
        chk_frame("b2b_f2", build(22'h2B0071, 32'h89ABCDEF, 1'b1));

        // Mid-frame reset during B3
        present(22'h155555, 32'hCAFEF00D, 1'b0);
        valid = 1'b0;
        repeat (3 * 10 * BD + 2 * BD) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_tx", tx, 1'b1);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_ready", ready, 1'b1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        present(22'h00ABCD, 32'h13572468, 1'b0);
        valid = 1'b0;
        rx_frame();
        chk_frame("post_rst", build(22'h00ABCD, 32'h13572468, 1'b0));
        chk("post_rst_ready_lat", rdy_at, EXP_RDY);

        repeat (20) @(negedge clk);
        cmp_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
